// File: rtl/axis_credit_issuer.sv
// axis_credit_issuer
// Issues one-cycle allow pulses that meter an upstream AXI4-Stream gate.
// After reset an initial credit burst is issued, then one credit is returned
// per drained packet (C_USE_TLAST=1) or beat (C_USE_TLAST=0).
// Optional build macro AXIS_CREDIT_ISSUER_RATE_LIMIT_EN adds a minimum gap of
// C_MIN_GAP idle cycles between pulses.
module axis_credit_issuer #(
    parameter int unsigned C_INIT_CREDITS = 8,
    parameter int unsigned C_USE_TLAST    = 0,
    parameter int unsigned C_MIN_GAP      = 0
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       mon_tvalid,
    input  logic       mon_tready,
    input  logic       mon_tlast,
    input  logic       en,
    output logic       m_allow,
    output logic [8:0] pending_count,
    output logic       init_done,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } state_t;

    localparam logic [8:0] INIT_LOAD = 9'(C_INIT_CREDITS);
    localparam logic [8:0] PEND_MAX  = '1;

    state_t     state;
    state_t     state_nxt;
    logic [8:0] init_cnt;
    logic [8:0] init_cnt_nxt;
    logic [8:0] pending_nxt;
    logic       init_done_nxt;
    logic       overflow_nxt;
    logic       ret;
    logic       gap_ok;
    logic       issue;
    logic       pend_dec;

    // Return event: a completed handshake, optionally qualified by tlast.
    always_comb begin
        ret = mon_tvalid & mon_tready & ((C_USE_TLAST != 0) ? mon_tlast : 1'b1);
    end

`ifdef AXIS_CREDIT_ISSUER_RATE_LIMIT_EN
    localparam logic [7:0] GAP_LOAD = 8'(C_MIN_GAP);
    logic [7:0] gap_cnt;

    // Gap counter: reloads on every pulse and counts down to zero.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            gap_cnt <= '0;
        end else if (issue) begin
            gap_cnt <= GAP_LOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end

    // A pulse may issue only once the gap has fully elapsed.
    always_comb begin
        gap_ok = (gap_cnt == '0);
    end
`else
    // No rate limiting: the gap condition always holds.
    always_comb begin
        gap_ok = 1'b1;
    end
`endif

    // Next-state, issue decision and credit accounting.
    always_comb begin
        state_nxt     = state;
        init_cnt_nxt  = init_cnt;
        pending_nxt   = pending_count;
        init_done_nxt = init_done;
        overflow_nxt  = overflow;
        issue         = 1'b0;
        pend_dec      = 1'b0;

        case (state)
            IDLE: begin
                state_nxt    = INIT;
                init_cnt_nxt = INIT_LOAD;
            end
            INIT: begin
                issue = en & gap_ok & (init_cnt != '0);
                if (issue) begin
                    init_cnt_nxt = init_cnt - 9'd1;
                end else if (init_cnt == '0) begin
                    state_nxt     = RUN;
                    init_done_nxt = 1'b1;
                end
            end
            RUN: begin
                issue    = en & gap_ok & (pending_count != '0);
                pend_dec = issue;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Returns accumulate in INIT and RUN; a return that meets a
        // simultaneous decrement leaves the count unchanged.
        if (state != IDLE) begin
            if (ret && !pend_dec) begin
                if (pending_count == PEND_MAX) begin
                    overflow_nxt = 1'b1;
                end else begin
                    pending_nxt = pending_count + 9'd1;
                end
            end else if (!ret && pend_dec) begin
                pending_nxt = pending_count - 9'd1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            init_cnt      <= '0;
            pending_count <= '0;
            init_done     <= 1'b0;
            overflow      <= 1'b0;
            m_allow       <= 1'b0;
        end else begin
            state         <= state_nxt;
            init_cnt      <= init_cnt_nxt;
            pending_count <= pending_nxt;
            init_done     <= init_done_nxt;
            overflow      <= overflow_nxt;
            m_allow       <= issue;
        end
    end

endmodule

// File: tb/tb_axis_credit_issuer.sv
// Self-checking bench for axis_credit_issuer: three instances with different
// configurations, a per-cycle credit model, and directed scenarios with
// hand-computed pulse timings.
module tb_axis_credit_issuer;

`ifdef AXIS_CREDIT_ISSUER_RATE_LIMIT_EN
    localparam bit RL_ON = 1'b1;
`else
    localparam bit RL_ON = 1'b0;
`endif

    localparam int P_INIT [3] = '{8, 4, 3};
    localparam int P_TL   [3] = '{1, 0, 0};
    localparam int P_GAP  [3] = '{0, 0, 3};

    logic       aclk;
    logic       rstn  [3];
    logic       tv    [3];
    logic       tr    [3];
    logic       tl    [3];
    logic       en    [3];
    logic       allow [3];
    logic [8:0] pend  [3];
    logic       done  [3];
    logic       ovf   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axis_credit_issuer #(
            .C_INIT_CREDITS(P_INIT[g]),
            .C_USE_TLAST   (P_TL[g]),
            .C_MIN_GAP     (P_GAP[g])
        ) u_dut (
            .aclk         (aclk),
            .aresetn      (rstn[g]),
            .mon_tvalid   (tv[g]),
            .mon_tready   (tr[g]),
            .mon_tlast    (tl[g]),
            .en           (en[g]),
            .m_allow      (allow[g]),
            .pending_count(pend[g]),
            .init_done    (done[g]),
            .overflow     (ovf[g])
        );
    end

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model state: phase 0=waiting for reset release, 1=initial burst, 2=steady
    int m_ph   [3];
    int m_init [3];
    int m_pend [3];
    int m_gap  [3];
    bit m_done [3];
    bit m_ovf  [3];
    bit m_al   [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_ph[i] = 0; m_init[i] = 0; m_pend[i] = 0; m_gap[i] = 0;
            m_done[i] = 0; m_ovf[i] = 0; m_al[i] = 0;
        end
    end

    // Credit model: owed credits as plain integers, clamped at 511.
    always @(posedge aclk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            bit r;
            bit fire;
            int dec;
            int nxt;
            if (!rstn[i]) begin
                m_ph[i] = 0; m_init[i] = 0; m_pend[i] = 0; m_gap[i] = 0;
                m_done[i] = 0; m_ovf[i] = 0; m_al[i] = 0;
            end else if (m_ph[i] == 0) begin
                m_ph[i]   = 1;
                m_init[i] = P_INIT[i];
                m_al[i]   = 0;
            end else begin
                r    = tv[i] && tr[i] && (P_TL[i] == 0 || tl[i]);
                fire = en[i] && (m_gap[i] == 0) &&
                       ((m_ph[i] == 1) ? (m_init[i] > 0) : (m_pend[i] > 0));
                dec  = (fire && m_ph[i] == 2) ? 1 : 0;
                nxt  = m_pend[i] + (r ? 1 : 0) - dec;
                if (nxt > 511) begin
                    nxt      = 511;
                    m_ovf[i] = 1;
                end
                m_pend[i] = nxt;
                if (m_ph[i] == 1) begin
                    if (fire) m_init[i] = m_init[i] - 1;
                    else if (m_init[i] == 0) begin
                        m_ph[i]   = 2;
                        m_done[i] = 1;
                    end
                end
                if (fire) m_gap[i] = RL_ON ? P_GAP[i] : 0;
                else if (m_gap[i] > 0) m_gap[i] = m_gap[i] - 1;
                m_al[i] = fire;
            end
        end
    end

    int pq0[$];
    int pq1[$];
    int pq2[$];
    int peak1 = 0;

    // Per-cycle comparison against the model, plus pulse-time recording.
    always @(negedge aclk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_allow", i), int'(allow[i]), int'(m_al[i]));
                chk($sformatf("u%0d_pending", i), int'(pend[i]), m_pend[i]);
                chk($sformatf("u%0d_init_done", i), int'(done[i]), int'(m_done[i]));
                chk($sformatf("u%0d_overflow", i), int'(ovf[i]), int'(m_ovf[i]));
            end
            if (allow[0]) pq0.push_back(cyc);
            if (allow[1]) pq1.push_back(cyc);
            if (allow[2]) pq2.push_back(cyc);
            if (int'(pend[1]) > peak1) peak1 = int'(pend[1]);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge aclk);
            #1;
        end
    endtask

    function automatic int qat(input int q[$], input int idx);
        if (idx < 0 || idx >= q.size()) return -1;
        return q[idx];
    endfunction

    int r, r2, r3, n0, n1, n2;
    int tl_edge[3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0; en[i] = 1'b1;
            tv[i] = 1'b0; tr[i] = 1'b0; tl[i] = 1'b0;
        end
        tick(3);
        for (int i = 0; i < 3; i++) begin
            chk("rst_allow", int'(allow[i]), 0);
            chk("rst_pending", int'(pend[i]), 0);
            chk("rst_init_done", int'(done[i]), 0);
            chk("rst_overflow", int'(ovf[i]), 0);
        end

        // Release reset; edge R enters the initial burst.
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
        tick(1);
        r = cyc;
        tick(1);
        // u1: beat returns sampled at edges R+2 and R+3, during its burst
        tv[1] = 1'b1; tr[1] = 1'b1;
        tick(2);
        tv[1] = 1'b0; tr[1] = 1'b0;
        tick(10);

        chk("burst8_count", pq0.size(), 8);
        chk("burst8_first", qat(pq0, 0), r + 1);
        chk("burst8_last", qat(pq0, 7), r + 8);
        chk("burst8_done", int'(done[0]), 1);
        chk("burst8_pending", int'(pend[0]), 0);

        chk("initret_count", pq1.size(), 6);
        chk("initret_4th", qat(pq1, 3), r + 4);
        chk("initret_6th", qat(pq1, 5), r + 7);
        chk("initret_peak", peak1, 2);

        chk("gap_count", pq2.size(), 3);
        chk("gap_first", qat(pq2, 0), r + 1);
        chk("gap_second", qat(pq2, 1), RL_ON ? r + 5 : r + 2);
        chk("gap_third", qat(pq2, 2), RL_ON ? r + 9 : r + 3);

        // u0 packet mode: non-handshake tlast beats first, then 3x4-beat packets
        n0 = pq0.size();
        tv[0] = 1'b1; tr[0] = 1'b0; tl[0] = 1'b1;
        tick(1);
        tv[0] = 1'b0; tr[0] = 1'b1; tl[0] = 1'b1;
        tick(1);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                tv[0] = 1'b1; tr[0] = 1'b1; tl[0] = (b == 3);
                tick(1);
                if (b == 3) tl_edge[p] = cyc;
            end
        end
        tv[0] = 1'b0; tr[0] = 1'b0; tl[0] = 1'b0;
        tick(3);
        chk("pkt_count", pq0.size() - n0, 3);
        for (int p = 0; p < 3; p++)
            chk($sformatf("pkt%0d_time", p), qat(pq0, n0 + p), tl_edge[p] + 1);
        chk("pkt_pending", int'(pend[0]), 0);

        // u1 simultaneous return and issue with one credit owed
        en[1] = 1'b0; tv[1] = 1'b1; tr[1] = 1'b1;
        tick(1);
        tv[1] = 1'b0; tr[1] = 1'b0;
        chk("simul_setup_pending", int'(pend[1]), 1);
        chk("simul_setup_allow", int'(allow[1]), 0);
        en[1] = 1'b1; tv[1] = 1'b1; tr[1] = 1'b1;
        tick(1);
        tv[1] = 1'b0; tr[1] = 1'b0;
        chk("simul_pending", int'(pend[1]), 1);
        chk("simul_allow", int'(allow[1]), 1);
        tick(1);
        chk("simul_next_allow", int'(allow[1]), 1);
        chk("simul_next_pending", int'(pend[1]), 0);
        tick(1);
        chk("simul_quiet", int'(allow[1]), 0);

        // u1 saturation with issue disabled, then drain
        en[1] = 1'b0;
        n1 = pq1.size();
        tv[1] = 1'b1; tr[1] = 1'b1;
        tick(515);
        tv[1] = 1'b0; tr[1] = 1'b0;
        tick(1);
        chk("sat_pending", int'(pend[1]), 511);
        chk("sat_overflow", int'(ovf[1]), 1);
        chk("sat_no_pulses", pq1.size() - n1, 0);
        en[1] = 1'b1;
        tick(515);
        chk("drain_count", pq1.size() - n1, 511);
        chk("drain_span", qat(pq1, n1 + 510) - qat(pq1, n1), 510);
        chk("drain_pending", int'(pend[1]), 0);
        chk("drain_overflow_sticky", int'(ovf[1]), 1);

        // u2 mid-burst reset discards owed and remaining init credits
        rstn[2] = 1'b0;
        tick(2);
        rstn[2] = 1'b1;
        tick(1);
        r2 = cyc;
        tv[2] = 1'b1; tr[2] = 1'b1;
        tick(2);
        tv[2] = 1'b0; tr[2] = 1'b0;
        n2 = pq2.size();
        chk("midrst_started", n2 > 0 ? qat(pq2, n2 - 1) : -1, RL_ON ? r2 + 1 : r2 + 2);
        rstn[2] = 1'b0;
        tick(4);
        chk("midrst_no_pulses", pq2.size() - n2, 0);
        chk("midrst_pending", int'(pend[2]), 0);
        chk("midrst_done", int'(done[2]), 0);
        rstn[2] = 1'b1;
        tick(1);
        r3 = cyc;
        tick(12);
        chk("reburst_count", pq2.size() - n2, 3);
        chk("reburst_first", qat(pq2, n2), r3 + 1);
        chk("reburst_last", qat(pq2, n2 + 2), RL_ON ? r3 + 9 : r3 + 3);
        chk("reburst_done", int'(done[2]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
